// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one synchronous video RAM between fixed-latency VGA fetches and CPU accesses.
// Video always wins the issue slot; CPU accesses fill idle slots and finish with a one-cycle ready pulse.
module vga_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] vid_address,
  input  logic              vid_req,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_VID  = 2'd1;
  localparam logic [1:0] TAG_RD   = 2'd2;
  localparam logic [1:0] TAG_WR   = 2'd3;
  logic [1:0]        st1_q, st1_d, st2_q, st2_d;
  logic              out_q, out_d, done_q, done_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d, cpu_dout_q, cpu_dout_d, ram_din_q, ram_din_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              cpu_ready_q, cpu_ready_d, ram_we_q, ram_we_d;
  logic              cpu_go, st2_cpu;
  // st2 marks the cycle in which ram_dout belongs to that slot's address
  always_comb begin
    cpu_go      = cpu_cs && !out_q && !done_q && !vid_req;
    st2_cpu     = (st2_q == TAG_RD) || (st2_q == TAG_WR);
    st1_d       = vid_req ? TAG_VID : cpu_go ? (cpu_we ? TAG_WR : TAG_RD) : TAG_NONE;
    st2_d       = st1_q;
    ram_addr_d  = vid_req ? vid_address : cpu_go ? cpu_address : ram_addr_q;
    ram_we_d    = cpu_go && cpu_we;
    ram_din_d   = cpu_go ? cpu_din : ram_din_q;
    vid_data_d  = (st2_q == TAG_VID) ? ram_dout : vid_data_q;
    cpu_dout_d  = (st2_q == TAG_RD) ? ram_dout : cpu_dout_q;
    cpu_ready_d = st2_cpu;
    out_d       = cpu_go || (out_q && !st2_cpu);
    done_d      = cpu_cs && (done_q || st2_cpu);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st1_q       <= TAG_NONE;
      st2_q       <= TAG_NONE;
      out_q       <= 1'b0;
      done_q      <= 1'b0;
      vid_data_q  <= '0;
      cpu_dout_q  <= '0;
      cpu_ready_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
    end else begin
      st1_q       <= st1_d;
      st2_q       <= st2_d;
      out_q       <= out_d;
      done_q      <= done_d;
      vid_data_q  <= vid_data_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_ready_q <= cpu_ready_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
    end
  end
  assign vid_data  = vid_data_q;
  assign cpu_dout  = cpu_dout_q;
  assign cpu_ready = cpu_ready_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_din   = ram_din_q;
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: directed checks of the arbiter against a behavioural synchronous RAM.
module tb_vga_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] vid_address = '0;
  logic        vid_req = 1'b0;
  logic [7:0]  vid_data;
  logic        cpu_cs = 1'b0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_address = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_ready;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = '0;
  logic        init = 1'b1;
  logic [7:0]  mem [0:8191];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  int          rdy_cnt = 0;
  int          we0, rdy0;

  vga_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .vid_address(vid_address), .vid_req(vid_req), .vid_data(vid_data),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_address(cpu_address), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Preload pattern: byte = addr ^ 0x5A, except 0x0040 holds 0xA5
  always @(posedge clk) begin
    if (init) begin
      for (int a = 0; a < 8192; a++) mem[a] <= (a == 'h40) ? 8'hA5 : (a[7:0] ^ 8'h5A);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  always @(posedge clk) begin
    if (ram_we) we_cnt <= we_cnt + 1;
    if (cpu_ready) rdy_cnt <= rdy_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic outs_zero(input string tag);
    check(tag, {vid_data, cpu_dout, cpu_ready, ram_addr, ram_we, ram_din}, 64'd0);
  endtask

  initial begin
    // reset held while requests toggle
    for (int i = 0; i < 6; i++) begin
      vid_req = i[0];
      vid_address = 13'h0123;
      cpu_cs = ~i[0];
      cpu_we = 1'b1;
      cpu_address = 13'h0456;
      cpu_din = 8'hEE;
      tick();
      init = 1'b0;
      outs_zero("reset_outs");
    end
    vid_req = 1'b0;
    cpu_cs = 1'b0;
    cpu_we = 1'b0;
    reset_n = 1'b1;
    tick(2);
    outs_zero("idle_after_reset");
    // first fetch after reset
    vid_req = 1'b1;
    vid_address = 13'h0040;
    tick();
    vid_req = 1'b0;
    tick();
    check("vid_first_n2", vid_data, 8'h00);
    tick();
    check("vid_first_n3", vid_data, 8'hA5);
    tick(13);
    // periodic fetch every 16 cycles
    for (int i = 0; i < 32; i++) begin
      vid_req = 1'b1;
      vid_address = 13'(i);
      tick();
      vid_req = 1'b0;
      tick();
      check("vid_per_n2", vid_data, (i == 0) ? 8'hA5 : (8'(i - 1) ^ 8'h5A));
      tick();
      check("vid_per_n3", vid_data, 8'(i) ^ 8'h5A);
      tick(13);
    end
    // CPU write to the top address
    we0 = we_cnt;
    cpu_cs = 1'b1;
    cpu_we = 1'b1;
    cpu_address = 13'h1FFF;
    cpu_din = 8'h3C;
    tick();
    check("wr_issue", {ram_we, ram_addr, ram_din}, {1'b1, 13'h1FFF, 8'h3C});
    check("wr_rdy_e1", cpu_ready, 1'b0);
    tick();
    check("wr_we_off", ram_we, 1'b0);
    check("wr_rdy_e2", cpu_ready, 1'b0);
    tick();
    check("wr_rdy_e3", cpu_ready, 1'b1);
    cpu_cs = 1'b0;
    tick();
    check("wr_rdy_pulse", cpu_ready, 1'b0);
    check("wr_we_count", we_cnt - we0, 1);
    // CPU read back
    cpu_cs = 1'b1;
    cpu_we = 1'b0;
    tick(2);
    check("rd_rdy_e2", cpu_ready, 1'b0);
    tick();
    check("rd_rdy_e3", {cpu_ready, cpu_dout}, {1'b1, 8'h3C});
    cpu_cs = 1'b0;
    tick();
    check("rd_hold", {cpu_ready, cpu_dout}, {1'b0, 8'h3C});
    tick(3);
    // collision: CPU read and video fetch in the same cycle
    cpu_cs = 1'b1;
    cpu_we = 1'b0;
    cpu_address = 13'h0005;
    vid_req = 1'b1;
    vid_address = 13'h0007;
    tick();
    vid_req = 1'b0;
    check("col_vid_first", {ram_we, ram_addr}, {1'b0, 13'h0007});
    tick();
    check("col_cpu_next", ram_addr, 13'h0005);
    tick();
    check("col_vid_lat", vid_data, 8'h5D);
    check("col_rdy_e3", cpu_ready, 1'b0);
    tick();
    check("col_rdy_e4", {cpu_ready, cpu_dout}, {1'b1, 8'h5F});
    cpu_cs = 1'b0;
    tick(3);
    // held chip select issues exactly once
    we0 = we_cnt;
    rdy0 = rdy_cnt;
    cpu_cs = 1'b1;
    cpu_we = 1'b1;
    cpu_address = 13'h0020;
    cpu_din = 8'h77;
    tick(23);
    check("held_we_count", we_cnt - we0, 1);
    check("held_rdy_count", rdy_cnt - rdy0, 1);
    cpu_cs = 1'b0;
    tick();
    cpu_cs = 1'b1;
    cpu_we = 1'b0;
    tick(3);
    check("held_reread", {cpu_ready, cpu_dout}, {1'b1, 8'h77});
    cpu_cs = 1'b0;
    tick(3);
    // reset one cycle after a write issue aborts it
    we0 = we_cnt;
    rdy0 = rdy_cnt;
    cpu_cs = 1'b1;
    cpu_we = 1'b1;
    cpu_address = 13'h0030;
    cpu_din = 8'h99;
    tick();
    check("abort_issue", ram_we, 1'b1);
    reset_n = 1'b0;
    cpu_cs = 1'b0;
    cpu_we = 1'b0;
    #1;
    outs_zero("abort_async");
    tick(3);
    reset_n = 1'b1;
    tick(5);
    outs_zero("abort_idle");
    check("abort_no_rdy", rdy_cnt - rdy0, 0);
    check("abort_no_we", we_cnt - we0, 0);
    cpu_cs = 1'b1;
    cpu_address = 13'h0030;
    tick(3);
    check("abort_mem_kept", {cpu_ready, cpu_dout}, {1'b1, 8'h6A});
    cpu_cs = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
